urng_range_sampler: RTL and testbench
=====================================

// Module: urng_range_sampler
// PURPOSE
//  Consumer end of the Tausworthe URNG output stream. Accepts 32-bit uniform words over
//  valid/ready and turns them into uniform integers in [0, range) by mask-and-reject sampling.
//  Buffers accepted results in a small FIFO for downstream use (dice, channel/noise selectors).
//  Keeps saturating statistics of consumed and rejected words.
// PARAMETERS
//  W           32  data width of URNG words and range
//  FIFO_DEPTH  4   output FIFO entries (power of 2, >=2)
//  CNT_W       16  width of the statistics counters
//  RESET_RANGE 0   range loaded at reset (0 = full 2^W, no rejection)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  range_load  in   1        pulse: load range_in, flush pipeline and FIFO
//  range_in    in   W        new range; 0 means 2^W
//  in_valid    in   1        URNG word valid
//  in_data     in   W        URNG word
//  in_ready    out  1        sampler accepts in_data this cycle
//  out_valid   out  1        out_data holds a sample
//  out_data    out  W        sample in [0, range)
//  out_ready   in   1        downstream takes out_data
//  busy        out  1        CFG state, or a word in flight or buffered
//  take_cnt    out  CNT_W    words consumed since reset/load (saturating)
//  reject_cnt  out  CNT_W    words rejected since reset/load (saturating)
// BEHAVIOUR
//  - Reset: state=CFG, range=RESET_RANGE, pipeline and FIFO empty, out_valid=0, out_data=0,
//    in_ready=0, counters=0. Asserting rst_n low at any time aborts everything immediately.
//  - FSM: CFG -> RUN after exactly 1 cycle. RUN -> CFG on range_load. No other states.
//  - CFG: mask computed and registered: r1=range-1 (W-bit wrap, so range 0 gives all ones);
//    mask = r1 with every bit below its MSB set; range 1 gives mask 0. in_ready=0.
//  - in_ready = (state==RUN) & ~range_load & (fifo_count + inflight < FIFO_DEPTH).
//    The credit check guarantees the FIFO never overflows. Handshake is in_valid & in_ready.
//  - Stage 1 (cycle after accept): cand = in_data & mask; take_cnt++.
//  - Stage 2: if range==0 or cand < range, push cand into the FIFO; otherwise drop it and
//    increment reject_cnt.
//  - Latency: a word accepted at edge N is visible on out_valid after edge N+2 when the FIFO
//    was empty. One word per cycle at full throughput; no bubbles unless rejected.
//  - FIFO: first-word-fall-through, order preserved. Push and pop in the same cycle keep
//    the count unchanged. out_data holds its last value while out_valid=0.
//  - Downstream: out_valid/out_data stay stable until out_ready; must not change while
//    out_valid & ~out_ready.
//  - range_load (any state): in_ready is forced 0 that cycle. Stages and FIFO are flushed.
//    Counters cleared and range latched at the edge; out_valid=0 from the next cycle; enters
//    CFG. A concurrent in_valid word is not consumed. A concurrent output pop is honoured.
//  - Counters saturate at all ones and never wrap.
//  - Rejection rate < 50% by construction (mask < 2*range).
// TESTING
//  1 range_load range_in=6, feed 5 -> mask=7; out_data=5 two cycles after accept; take_cnt=1.
//  2 range=6, feed 0x00000007 then 0xFFFFFFF2 -> first rejected (reject_cnt=1); out_data=2.
//  3 Reset range (0), feed 0xDEADBEEF -> out_data=0xDEADBEEF, reject_cnt stays 0.
//  4 range=1, feed 0x12345678, 0xFFFFFFFF -> two outputs, both 0; no rejects.
//  5 out_ready=0, continuous in_valid -> in_ready drops once FIFO_DEPTH words are buffered
//    or in flight; release out_ready -> all words emerge in order, none lost.
//  6 range_load with 3 words buffered and in_valid=1 -> out_valid=0 next cycle, counters=0;
//    in_ready=0 for 2 cycles; rst_n pulse mid-stream gives the same empty state.

Source files
------------

// File: rtl/urng_range_sampler.sv
// Mask-and-reject range sampler for a 32-bit URNG word stream.
// Produces uniform integers in [0, range), buffered in a small first-word-fall-through FIFO.
module urng_range_sampler #(
  parameter int             W           = 32,
  parameter int             FIFO_DEPTH  = 4,
  parameter int             CNT_W       = 16,
  parameter logic [W-1:0]   RESET_RANGE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             range_load,
  input  logic [W-1:0]     range_in,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] take_cnt,
  output logic [CNT_W-1:0] reject_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {CFG, RUN} state_t;

  state_t state, state_nxt;

  logic [W-1:0]  range_q;
  logic [W-1:0]  mask_q;
  logic [W-1:0]  data_p0;
  logic [W-1:0]  cand_p1;
  logic          vld_p0;
  logic          vld_p1;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  last_q;
  logic [AW+1:0] occ;
  logic          accept;
  logic          keep_p1;
  logic          push;
  logic          pop;

  // Smear every bit below the MSB of r1 to one.
  function automatic logic [W-1:0] smear_mask(input logic [W-1:0] r1);
    logic [W-1:0] m;
    m = r1;
    for (int i = W - 2; i >= 0; i--) m[i] = m[i] | m[i+1];
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      CFG:     state_nxt = RUN;
      default: state_nxt = state;
    endcase
    if (range_load) state_nxt = CFG;
  end

  // Credit covers FIFO entries plus words still travelling through p0/p1.
  assign occ       = {1'b0, count} + {{(AW+1){1'b0}}, vld_p0} + {{(AW+1){1'b0}}, vld_p1};
  assign in_ready  = (state == RUN) & ~range_load & (occ < (AW+2)'(FIFO_DEPTH));
  assign accept    = in_valid & in_ready;
  assign keep_p1   = (range_q == '0) | (cand_p1 < range_q);
  assign push      = vld_p1 & keep_p1 & ~range_load;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : last_q;
  assign busy      = (state == CFG) | vld_p0 | vld_p1 | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CFG;
      range_q    <= RESET_RANGE;
      mask_q     <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      take_cnt   <= '0;
      reject_cnt <= '0;
      last_q     <= '0;
    end else begin
      state <= state_nxt;
      if (pop) last_q <= mem[rd_ptr];
      if (range_load) begin
        range_q    <= range_in;
        vld_p0     <= 1'b0;
        vld_p1     <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        take_cnt   <= '0;
        reject_cnt <= '0;
      end else begin
        if (state == CFG) mask_q <= smear_mask(range_q - 1'b1);
        vld_p0 <= accept;
        vld_p1 <= vld_p0;
        if (vld_p0) take_cnt <= sat_inc(take_cnt);
        if (vld_p1 && !keep_p1) reject_cnt <= sat_inc(reject_cnt);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end

  // p0: raw word captured at accept; p1: masked candidate; then FIFO write.
  always_ff @(posedge clk) begin
    if (accept) data_p0 <= in_data;
    if (vld_p0) cand_p1 <= data_p0 & mask_q;
    if (push) mem[wr_ptr] <= cand_p1;
  end

endmodule

// File: tb/tb_urng_range_sampler.sv
// Directed bench for urng_range_sampler with an output scoreboard fed by an accept monitor.
module tb_urng_range_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        range_load;
  logic [31:0] range_in;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic [15:0] take_cnt;
  logic [15:0] reject_cnt;

  int tests = 0;
  int fails = 0;
  int accepted = 0;
  int base;
  logic [31:0] sb [$];
  logic [31:0] obs_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] model_range = '0;
  logic [31:0] cand;

  urng_range_sampler dut (
    .clk(clk), .rst_n(rst_n), .range_load(range_load), .range_in(range_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .take_cnt(take_cnt), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_mask(input logic [31:0] r);
    logic [31:0] r1;
    logic [32:0] m;
    int msb;
    r1 = r - 32'd1;
    if (r1 == 32'd0) return 32'd0;
    msb = 0;
    for (int i = 0; i < 32; i++) if (r1[i]) msb = i;
    m = (33'd1 << (msb + 1)) - 33'd1;
    return m[31:0];
  endfunction

  // Monitor: records accepted words into the model and output pops against it.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      model_range = '0;
    end else begin
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        if (sb.size() > 0) exp_q.push_back(sb.pop_front());
        else exp_q.push_back('x);
      end
      if (range_load) begin
        sb.delete();
        model_range = range_in;
      end else if (in_valid && in_ready) begin
        accepted++;
        cand = in_data & model_mask(model_range);
        if (model_range == 32'd0 || cand < model_range) sb.push_back(cand);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    logic [31:0] o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("sb_out_data", o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic load_range(input logic [31:0] r);
    range_in = r;
    range_load = 1'b1;
    tick();
    range_load = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; range_load = 1'b0; range_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_take", {16'd0, take_cnt}, 32'd0);
    check("rst_reject", {16'd0, reject_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b1;
    tick();
    check("run_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // range 6, single word of latency
    range_in = 32'd6; range_load = 1'b1; #1;
    check("load_forces_ready", {31'd0, in_ready}, 32'd0);
    tick();
    range_load = 1'b0;
    check("cfg_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b1; in_data = 32'd5;
    tick();
    in_valid = 1'b0;
    check("lat_n0_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_take", {16'd0, take_cnt}, 32'd1);
    check("lat_n1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_n2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_n2_data", out_data, 32'd5);

    // reject then accept
    in_valid = 1'b1; in_data = 32'h0000_0007;
    tick();
    in_data = 32'hFFFF_FFF2;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("rej_reject", {16'd0, reject_cnt}, 32'd1);
    check("rej_take", {16'd0, take_cnt}, 32'd3);
    check("rej_valid", {31'd0, out_valid}, 32'd0);
    check("rej_hold_data", out_data, 32'd2);

    // back to reset range (full width, no rejection)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_data", out_data, 32'hDEAD_BEEF);
    tick();
    check("full_reject", {16'd0, reject_cnt}, 32'd0);
    check("full_take", {16'd0, take_cnt}, 32'd1);

    // range 1 always yields zero
    load_range(32'd1);
    in_valid = 1'b1; in_data = 32'h1234_5678;
    tick();
    in_data = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("r1_take", {16'd0, take_cnt}, 32'd2);
    check("r1_reject", {16'd0, reject_cnt}, 32'd0);
    check("r1_data", out_data, 32'd0);

    // backpressure: credit limit then drain in order
    load_range(32'd8);
    out_ready = 1'b0;
    base = accepted;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'd100 + 32'(i);
      tick();
    end
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_accepted", 32'(accepted - base), 32'd4);
    check("bp_head", out_data, 32'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    check("bp_last", out_data, 32'd7);

    // range_load with words buffered and a word offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'd9 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("fl_pre_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1; in_data = 32'h55;
    out_ready = 1'b1;
    range_in = 32'd8; range_load = 1'b1; #1;
    check("fl_load_ready", {31'd0, in_ready}, 32'd0);
    tick();
    range_load = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_take", {16'd0, take_cnt}, 32'd0);
    check("fl_reject", {16'd0, reject_cnt}, 32'd0);
    check("fl_cfg_ready", {31'd0, in_ready}, 32'd0);
    check("fl_popped", out_data, 32'd1);
    tick();
    in_valid = 1'b0;
    check("fl_run_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) tick();
    check("fl_not_taken", {16'd0, take_cnt}, 32'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd3;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_ready", {31'd0, in_ready}, 32'd0);
    check("ar_take", {16'd0, take_cnt}, 32'd0);
    check("ar_data", out_data, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_run_ready", {31'd0, in_ready}, 32'd1);
    check("ar_idle", {31'd0, busy}, 32'd0);
    check("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
